mul_seq: RTL and testbench
==========================

Name: mul_seq

Overview:
- Iterative 16x16 multiply sequencer. Time-shares the existing combinational ALU with the execute stage and drives its func/src/shamt inputs.
- Uses ALU ADD and SLL operations to build the low 16 bits of the product by shift-add.
- Sits beside EX. Holds `alu_grant`/`busy` high so the pipeline mux hands it the ALU and the hazard unit stalls IF/ID/EX.

Parameters:
- `WIDTH`, 16, operand and product width (fixed by the ALU; other values unsupported)
- `CNT_W`, 5, iteration counter width (counts 0..WIDTH)

Ports:
- `clk` input 1: system clock, all state on rising edge
- `rst` input 1: synchronous, active-high reset
- `start` input 1: request a multiply; sampled only in IDLE
- `op_a` input 16: multiplicand
- `op_b` input 16: multiplier
- `busy` output 1: high in every non-IDLE state; stalls pipeline
- `done` output 1: one-cycle pulse, product valid
- `product` output 16: low 16 bits of op_a*op_b; held until the next accepted start
- `alu_grant` output 1: high in ADD/SHIFT; selects sequencer onto the ALU inputs
- `alu_src0` output 16: ALU operand 0
- `alu_src1` output 16: ALU operand 1
- `alu_shamt` output 4: ALU shift amount
- `alu_func` output 3: ALU function code
- `alu_paddsb` output 1: tied 0
- `alu_llb` output 1: tied 0
- `alu_dst` input 16: ALU result (combinational, same cycle)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (any state, including mid-operation):
  - state = IDLE
  - acc, mcand, mplier, cnt, product = 0
  - busy = done = alu_grant = 0
  - alu_src0/src1/shamt/func = 0
- Internal registers:
  - acc[15:0]: running product
  - mcand[15:0]: shifted multiplicand
  - mplier[15:0]: remaining multiplier
  - cnt: bits consumed
- Operation order:
  - An iteration is one cycle in ADD (only if mplier[0]=1), followed by one cycle in SHIFT.
  - Each ALU result is registered at the clock edge ending the cycle that drives it.
- IDLE:
  - On start=1: load acc=0, mcand=op_a, mplier=op_b, cnt=0.
  - Next state is ADD if op_b[0]=1, else SHIFT.
  - start=0: stay in IDLE.
- ADD:
  - Drive alu_func=000 (ADD), src0=acc, src1=mcand, shamt=0.
  - Capture acc <= alu_dst.
  - Next state SHIFT.
  - ALU ov is ignored; product is modulo 2^16, valid for unsigned and two's-complement operands alike.
- SHIFT:
  - Drive alu_func=101 (SLL), src0=mcand, src1=0, shamt=1.
  - Capture mcand <= alu_dst, mplier <= mplier>>1 (local logic), cnt <= cnt+1.
  - Next state is DONE if cnt+1==WIDTH (or early exit, see Optional Feature).
  - Otherwise next state is ADD if the shifted mplier[0]=1, else SHIFT.
- DONE:
  - product <= acc, done=1 for exactly this cycle, busy=1.
  - Next state IDLE unconditionally.
- When alu_grant=0, alu_* outputs are driven 0.
- start while busy: ignored, no queuing; the first cycle a new start can be accepted is the cycle after DONE.
- Latency, fixed-mode build: (number of 1 bits in op_b) + 16 + 1 cycles from the start-accept edge to the done pulse. Min 17, max 33.

Optional Feature:
- Macro: `MUL_EARLY_EXIT_EN`
- Defined:
  - In IDLE, start with op_b==0 goes straight to DONE (product=0, done one cycle after accept).
  - In SHIFT, if the shifted mplier==0, go to DONE regardless of cnt.
  - Latency = popcount(op_b) + (index of highest set bit + 1) + 1.
- Undefined: always WIDTH SHIFT cycles (fixed latency above); timing is data-independent except for ADD cycles.

Decomposition:
- Shared package `cpu_pkg` holds:
  - ALU function constants: ALU_ADD=3'b000, ALU_PADDSB=3'b001, ALU_SUB=3'b010, ALU_AND=3'b011, ALU_NOR=3'b100, ALU_SLL=3'b101, ALU_SRL=3'b110, ALU_SRA=3'b111.
  - mul_seq state encoding: IDLE, ADD, SHIFT, DONE.
- No sub-module: a single FSM plus datapath registers. The ALU is external and shared, not instantiated here.

Test Plan:
- op_a=3, op_b=5, fixed mode:
  - product=15, done exactly 19 cycles after accept.
  - With `MUL_EARLY_EXIT_EN`: done 6 cycles after accept, sequence ADD, SHIFT, SHIFT, ADD, SHIFT, DONE.
- op_a=16'hFFFF, op_b=16'hFFFF:
  - product=16'h0001, done 33 cycles after accept.
  - alu_func alternates 000/101 every cycle.
- op_a=16'h1234, op_b=0:
  - product=0, no ADD cycles.
  - Early-exit build: done 1 cycle after accept.
- op_a=16'hFFFE (-2), op_b=16'h0003: product=16'hFFFA (-6).
- start pulsed again while busy, with op_a=7, op_b=7:
  - Ignored; first product unchanged, done pulses once.
  - A new start the cycle after DONE is accepted.
- rst asserted on the 5th busy cycle:
  - Next cycle: state IDLE, busy=0, alu_grant=0, product=0, done never pulses.
  - A following start with op_a=2, op_b=9 gives product=18.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU function codes and the multiply sequencer state encoding.
package cpu_pkg;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_PADDSB = 3'b001;
  localparam logic [2:0] ALU_SUB    = 3'b010;
  localparam logic [2:0] ALU_AND    = 3'b011;
  localparam logic [2:0] ALU_NOR    = 3'b100;
  localparam logic [2:0] ALU_SLL    = 3'b101;
  localparam logic [2:0] ALU_SRL    = 3'b110;
  localparam logic [2:0] ALU_SRA    = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } mul_state_t;

endpackage

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier that borrows the shared ALU while the pipeline is stalled.
// Optional build macro MUL_EARLY_EXIT_EN ends the operation once no multiplier bits remain.
module mul_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             alu_grant,
  output logic [WIDTH-1:0] alu_src0,
  output logic [WIDTH-1:0] alu_src1,
  output logic [3:0]       alu_shamt,
  output logic [2:0]       alu_func,
  output logic             alu_paddsb,
  output logic             alu_llb,
  input  logic [WIDTH-1:0] alu_dst
);

  mul_state_t       state, state_nxt;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mplier_shr;
  logic [CNT_W-1:0] cnt_nxt;

  assign alu_paddsb = 1'b0;
  assign alu_llb    = 1'b0;

  // Next-state decode and ALU operand drive; ALU outputs stay zero unless granted.
  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    alu_grant  = 1'b0;
    alu_src0   = '0;
    alu_src1   = '0;
    alu_shamt  = 4'd0;
    alu_func   = 3'b000;
    mplier_shr = mplier >> 1;
    cnt_nxt    = cnt + 1'b1;

    case (state)
      IDLE: begin
        if (start) begin
`ifdef MUL_EARLY_EXIT_EN
          if (op_b == '0)
            state_nxt = DONE;
          else
            state_nxt = op_b[0] ? ADD : SHIFT;
`else
          state_nxt = op_b[0] ? ADD : SHIFT;
`endif
        end
      end
      ADD: begin
        alu_grant = 1'b1;
        alu_func  = ALU_ADD;
        alu_src0  = acc;
        alu_src1  = mcand;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        alu_grant = 1'b1;
        alu_func  = ALU_SLL;
        alu_src0  = mcand;
        alu_shamt = 4'd1;
        if (cnt_nxt == CNT_W'(WIDTH))
          state_nxt = DONE;
`ifdef MUL_EARLY_EXIT_EN
        else if (mplier_shr == '0)
          state_nxt = DONE;
`endif
        else
          state_nxt = mplier_shr[0] ? ADD : SHIFT;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus datapath; ALU results land at the edge that ends the driving cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= op_a;
            mplier <= op_b;
            cnt    <= '0;
          end
        end
        ADD: acc <= alu_dst;
        SHIFT: begin
          mcand  <= alu_dst;
          mplier <= mplier_shr;
          cnt    <= cnt_nxt;
        end
        DONE: product <= acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq with a behavioural model of the shared ALU.
// Honours MUL_EARLY_EXIT_EN for the expected latencies.
module tb_mul_seq;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] op_a, op_b;
  logic        busy, done, alu_grant, alu_paddsb, alu_llb;
  logic [15:0] product, alu_src0, alu_src1, alu_dst;
  logic [3:0]  alu_shamt;
  logic [2:0]  alu_func;

  mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product), .alu_grant(alu_grant),
    .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_shamt(alu_shamt),
    .alu_func(alu_func), .alu_paddsb(alu_paddsb), .alu_llb(alu_llb),
    .alu_dst(alu_dst)
  );

  // Only the two functions the sequencer uses are modelled.
  assign alu_dst = (alu_func == 3'b000) ? alu_src0 + alu_src1 :
                   (alu_func == 3'b101) ? alu_src0 << alu_shamt : 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
    int          adds;
    int          lat_fix;
    int          lat_early;
  } vec_t;

  vec_t       vecs [8];
  int         checks = 0;
  int         passed = 0;
  int         lat;
  int         add_cnt;
  logic [2:0] func_hist [0:127];
  logic       grant_hist [0:127];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic sampleCycle(input int idx);
    grant_hist[idx] = alu_grant;
    func_hist[idx]  = alu_grant ? alu_func : 3'b111;
    if (alu_grant && alu_func == 3'b000) add_cnt++;
  endtask

  // Issue one multiply from IDLE and wait (bounded) for done; lat counts cycles from accept.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    start = 1'b1; op_a = a; op_b = b;
    add_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    sampleCycle(lat);
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      sampleCycle(lat);
    end
    if (!done) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  function automatic int pickLat(input int fix, input int early);
`ifdef MUL_EARLY_EXIT_EN
    return early;
`else
    return fix;
`endif
  endfunction

  int cyc;
  int pulses;
  int exp_lat;

  initial begin
    vecs[0] = '{16'h0003, 16'h0005, 16'h000F, 2, 19, 6};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16, 33, 33};
    vecs[2] = '{16'h1234, 16'h0000, 16'h0000, 0, 17, 1};
    vecs[3] = '{16'hFFFE, 16'h0003, 16'hFFFA, 2, 19, 5};
    vecs[4] = '{16'h0002, 16'h0009, 16'h0012, 2, 19, 7};
    vecs[5] = '{16'h00FF, 16'h0101, 16'hFFFF, 2, 19, 12};
    vecs[6] = '{16'h8000, 16'h8000, 16'h0000, 1, 18, 18};
    vecs[7] = '{16'h1234, 16'h0001, 16'h1234, 1, 18, 3};

    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_grant", {31'd0, alu_grant}, 32'd0);
    checkOutput("reset_product", {16'd0, product}, 32'd0);
    checkOutput("reset_alu", {alu_src0, alu_src1}, 32'd0);
    checkOutput("reset_func_shamt", {25'd0, alu_func, alu_shamt}, 32'd0);
    checkOutput("tied_paddsb_llb", {30'd0, alu_paddsb, alu_llb}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b);
      checkOutput($sformatf("latency[%0d]", i), lat, pickLat(vecs[i].lat_fix, vecs[i].lat_early));
      checkOutput($sformatf("adds[%0d]", i), add_cnt, vecs[i].adds);
      @(posedge clk); #1;
      checkOutput($sformatf("done_width[%0d]", i), {31'd0, done}, 32'd0);
      checkOutput($sformatf("product[%0d]", i), {16'd0, product}, {16'd0, vecs[i].p});
    end

    // All-ones operands: ADD and SLL must alternate on every busy cycle.
    applyStimulus(16'hFFFF, 16'hFFFF);
    cyc = 0;
    for (int k = 1; k <= 32; k++) begin
      if (!grant_hist[k] || func_hist[k] != ((k % 2 == 1) ? 3'b000 : 3'b101)) cyc++;
    end
    checkOutput("ffff_alternation_errors", cyc, 0);
    checkOutput("ffff_done_cycle_grant", {31'd0, grant_hist[33]}, 32'd0);
    @(posedge clk); #1;

    // A start pulse while busy must be ignored.
    start = 1'b1; op_a = 16'd3; op_b = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (cyc == 3) begin start = 1'b1; op_a = 16'd7; op_b = 16'd7; end
      if (cyc == 4) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("busy_start_latency", cyc, pickLat(19, 6));
    start = 1'b1; op_a = 16'd7; op_b = 16'd7;
    @(posedge clk); #1;
    checkOutput("after_done_idle", {31'd0, busy}, 32'd0);
    checkOutput("busy_start_product", {16'd0, product}, 32'd15);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("restart_accepted", {31'd0, busy}, 32'd1);
    cyc = 2;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("restart_done_seen", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    checkOutput("restart_product", {16'd0, product}, 32'd49);

    // Reset on the 5th busy cycle aborts the operation cleanly.
    start = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_grant", {31'd0, alu_grant}, 32'd0);
    checkOutput("abort_product", {16'd0, product}, 32'd0);
    checkOutput("abort_func", {29'd0, alu_func}, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    checkOutput("abort_no_activity", pulses, 0);
    applyStimulus(16'd2, 16'd9);
    checkOutput("post_abort_latency", lat, pickLat(19, 7));
    @(posedge clk); #1;
    checkOutput("post_abort_product", {16'd0, product}, 32'd18);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
